// File: rtl/fifo_spi_tx.sv
// fifo_spi_tx: drains a falling-edge-strobe FIFO and shifts each word out as SPI mode 0.
// Define FIFO_SPI_TX_CS_EN to add the cs_n framing output.
module fifo_spi_tx #(
  parameter int WORD_SIZE = 8,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [WORD_SIZE-1:0] fifo_q,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 busy,
`ifdef FIFO_SPI_TX_CS_EN
  output logic                 word_done,
  output logic                 cs_n
`else
  output logic                 word_done
`endif
);

  localparam int         CNT_W    = $clog2(WORD_SIZE + 1);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WORD_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_POP,
    S_SHIFT
  } state_t;

  state_t               state, state_d;
  logic [WORD_SIZE-1:0] shift_reg, shift_d;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_d;
  logic [7:0]           div_cnt, div_d;
  logic                 fifo_read_d, sclk_d, mosi_d, busy_d, word_done_d;
  logic [WORD_SIZE-1:0] shifted;
  logic                 start;

`ifdef FIFO_SPI_TX_CS_EN
  localparam logic [8:0] CS_HOLD = 9'(2 * CLK_DIV);
  logic       cs_n_d;
  logic [8:0] cs_cnt, cs_cnt_d;
`endif

  function automatic logic lead_bit(input logic [WORD_SIZE-1:0] w);
    return MSB_FIRST ? w[WORD_SIZE-1] : w[0];
  endfunction

  function automatic logic [WORD_SIZE-1:0] advance(input logic [WORD_SIZE-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign start   = enable && !fifo_empty;
  assign shifted = advance(shift_reg);

  always_comb begin
    state_d     = state;
    shift_d     = shift_reg;
    bit_cnt_d   = bit_cnt;
    div_d       = div_cnt;
    fifo_read_d = fifo_read;
    sclk_d      = sclk;
    mosi_d      = mosi;
    busy_d      = busy;
    word_done_d = 1'b0;
`ifdef FIFO_SPI_TX_CS_EN
    cs_n_d      = cs_n;
    cs_cnt_d    = cs_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          // busy and cs_n assert on entry so they are already high/low during LATCH
          state_d = S_LATCH;
          busy_d  = 1'b1;
`ifdef FIFO_SPI_TX_CS_EN
          cs_n_d   = 1'b0;
          cs_cnt_d = '0;
`endif
        end
`ifdef FIFO_SPI_TX_CS_EN
        else if (cs_cnt != '0) begin
          cs_cnt_d = cs_cnt - 9'd1;
          if (cs_cnt == 9'd1) cs_n_d = 1'b1;
        end
`endif
      end
      S_LATCH: begin
        shift_d     = fifo_q;
        fifo_read_d = 1'b1;
        state_d     = S_POP;
      end
      S_POP: begin
        fifo_read_d = 1'b0;
        mosi_d      = lead_bit(shift_reg);
        sclk_d      = 1'b0;
        bit_cnt_d   = '0;
        div_d       = '0;
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_d = '0;
          if (!sclk) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt == BIT_LAST) begin
              word_done_d = 1'b1;
              busy_d      = 1'b0;
              state_d     = S_IDLE;
`ifdef FIFO_SPI_TX_CS_EN
              cs_cnt_d    = CS_HOLD;
`endif
            end else begin
              bit_cnt_d = bit_cnt + CNT_W'(1);
              shift_d   = shifted;
              mosi_d    = lead_bit(shifted);
            end
          end
        end else begin
          div_d = div_cnt + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      fifo_read <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
`ifdef FIFO_SPI_TX_CS_EN
      cs_n      <= 1'b1;
      cs_cnt    <= '0;
`endif
    end else begin
      state     <= state_d;
      shift_reg <= shift_d;
      bit_cnt   <= bit_cnt_d;
      div_cnt   <= div_d;
      fifo_read <= fifo_read_d;
      sclk      <= sclk_d;
      mosi      <= mosi_d;
      busy      <= busy_d;
      word_done <= word_done_d;
`ifdef FIFO_SPI_TX_CS_EN
      cs_n      <= cs_n_d;
      cs_cnt    <= cs_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_spi_tx.sv
// Directed bench for fifo_spi_tx: two instances (MSB-first and LSB-first, CLK_DIV=2) each fed by a FIFO model.
module tb_fifo_spi_tx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // FIFO models: tail/mem written by stimulus only, head advanced on read strobe falling edge
  logic [7:0] amem [32];
  logic [7:0] bmem [32];
  logic [4:0] a_head = '0, a_tail = '0, b_head = '0, b_tail = '0;
  logic [7:0] a_q, b_q;
  logic a_empty, b_empty;
  assign a_q = amem[a_head];
  assign b_q = bmem[b_head];
  assign a_empty = (a_head == a_tail);
  assign b_empty = (b_head == b_tail);

  logic a_read, a_sclk, a_mosi, a_busy, a_done;
  logic b_read, b_sclk, b_mosi, b_busy, b_done;
`ifdef FIFO_SPI_TX_CS_EN
  logic a_cs_n, b_cs_n;
`endif

  fifo_spi_tx #(.WORD_SIZE(8), .CLK_DIV(2), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .enable(en_a), .fifo_q(a_q), .fifo_empty(a_empty),
    .fifo_read(a_read), .sclk(a_sclk), .mosi(a_mosi), .busy(a_busy),
`ifdef FIFO_SPI_TX_CS_EN
    .cs_n(a_cs_n),
`endif
    .word_done(a_done)
  );

  fifo_spi_tx #(.WORD_SIZE(8), .CLK_DIV(2), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .enable(en_b), .fifo_q(b_q), .fifo_empty(b_empty),
    .fifo_read(b_read), .sclk(b_sclk), .mosi(b_mosi), .busy(b_busy),
`ifdef FIFO_SPI_TX_CS_EN
    .cs_n(b_cs_n),
`endif
    .word_done(b_done)
  );

  logic a_rd_p = 1'b0, b_rd_p = 1'b0;
  always @(negedge clk) begin
    if (a_rd_p && !a_read && !a_empty) a_head <= a_head + 5'd1;
    if (b_rd_p && !b_read && !b_empty) b_head <= b_head + 5'd1;
    a_rd_p <= a_read;
    b_rd_p <= b_read;
  end

  // Event log, sampled mid-cycle
  logic a_bits[$], b_bits[$];
  int a_latch[$], a_done_q[$], a_fall[$], a_bfall[$], b_done_q[$];
  int a_pulses = 0, a_high = 0, b_pulses = 0;
  int cs_fall[$], cs_rise[$];
  logic a_sclk_p = 1'b0, a_busy_p = 1'b0, a_read_p = 1'b0;
  logic b_sclk_p = 1'b0, b_read_p = 1'b0, cs_p = 1'b1;
  always @(negedge clk) begin
    if (a_sclk && !a_sclk_p) a_bits.push_back(a_mosi);
    if (!a_sclk && a_sclk_p) a_fall.push_back(cyc);
    if (a_busy && !a_busy_p) a_latch.push_back(cyc);
    if (!a_busy && a_busy_p) a_bfall.push_back(cyc);
    if (a_done) a_done_q.push_back(cyc);
    if (a_read) a_high <= a_high + 1;
    if (a_read && !a_read_p) a_pulses <= a_pulses + 1;
    if (b_sclk && !b_sclk_p) b_bits.push_back(b_mosi);
    if (b_done) b_done_q.push_back(cyc);
    if (b_read && !b_read_p) b_pulses <= b_pulses + 1;
    a_sclk_p <= a_sclk;
    a_busy_p <= a_busy;
    a_read_p <= a_read;
    b_sclk_p <= b_sclk;
    b_read_p <= b_read;
`ifdef FIFO_SPI_TX_CS_EN
    if (a_cs_n && !cs_p) cs_rise.push_back(cyc);
    if (!a_cs_n && cs_p) cs_fall.push_back(cyc);
    cs_p <= a_cs_n;
`endif
  end

  task automatic push_a(input logic [7:0] v);
    amem[a_tail] = v;
    a_tail = a_tail + 5'd1;
  endtask

  task automatic push_b(input logic [7:0] v);
    bmem[b_tail] = v;
    b_tail = b_tail + 5'd1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({a_sclk, a_mosi, a_busy, a_read, a_done} !== 5'b0) begin
      errors++; $display("FAIL reset_a outputs got=%b want=00000", {a_sclk, a_mosi, a_busy, a_read, a_done});
    end
    checks++; if ({b_sclk, b_mosi, b_busy, b_read, b_done} !== 5'b0) begin
      errors++; $display("FAIL reset_b outputs got=%b want=00000", {b_sclk, b_mosi, b_busy, b_read, b_done});
    end
`ifdef FIFO_SPI_TX_CS_EN
    checks++; if (a_cs_n !== 1'b1) begin
      errors++; $display("FAIL reset_cs_n got=%b want=1", a_cs_n);
    end
`endif
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single;
    int bl = a_latch.size(), bd = a_done_q.size(), bb = a_bits.size();
    int p0 = a_pulses, h0 = a_high;
    logic [7:0] v = '0;
    push_a(8'hA5);
    en_a = 1'b1;
    for (int i = 0; i < 200 && a_done_q.size() < bd + 1; i++) @(negedge clk);
    checks++; if (a_done_q.size() < bd + 1) begin
      errors++; $display("FAIL single_timeout got=%0d want=%0d dones", a_done_q.size() - bd, 1);
    end
    en_a = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) v = {v[6:0], a_bits[bb + i]};
    checks++; if (v !== 8'hA5) begin errors++; $display("FAIL single_bits got=%h want=a5", v); end
    checks++; if (a_pulses - p0 != 1) begin errors++; $display("FAIL single_pulses got=%0d want=1", a_pulses - p0); end
    checks++; if (a_high - h0 != 1) begin errors++; $display("FAIL single_read_width got=%0d want=1", a_high - h0); end
    checks++; if (a_done_q[bd] - a_latch[bl] != 34) begin
      errors++; $display("FAIL single_latency got=%0d want=34", a_done_q[bd] - a_latch[bl]);
    end
    checks++; if (a_empty !== 1'b1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL single_end empty/busy got=%b%b want=10", a_empty, a_busy);
    end
  endtask

  task automatic test_burst;
    int bl = a_latch.size(), bd = a_done_q.size(), bb = a_bits.size();
    int bf = a_fall.size(), bbf = a_bfall.size(), p0 = a_pulses;
    logic [7:0] exp_w [3] = '{8'h01, 8'h80, 8'h3C};
    logic [7:0] v;
    for (int k = 0; k < 3; k++) push_a(exp_w[k]);
    en_a = 1'b1;
    for (int i = 0; i < 400 && a_done_q.size() < bd + 3; i++) @(negedge clk);
    checks++; if (a_done_q.size() < bd + 3) begin
      errors++; $display("FAIL burst_timeout got=%0d want=3 dones", a_done_q.size() - bd);
    end
    repeat (10) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      v = '0;
      for (int i = 0; i < 8; i++) v = {v[6:0], a_bits[bb + 8 * k + i]};
      checks++; if (v !== exp_w[k]) begin errors++; $display("FAIL burst_word%0d got=%h want=%h", k, v, exp_w[k]); end
    end
    checks++; if (a_pulses - p0 != 3 || a_latch.size() - bl != 3) begin
      errors++; $display("FAIL burst_pulses got=%0d/%0d want=3/3", a_pulses - p0, a_latch.size() - bl);
    end
    checks++; if (a_latch[bl + 1] - a_fall[bf + 7] != 1 || a_latch[bl + 2] - a_fall[bf + 15] != 1) begin
      errors++; $display("FAIL burst_gap got=%0d,%0d want=1,1", a_latch[bl + 1] - a_fall[bf + 7], a_latch[bl + 2] - a_fall[bf + 15]);
    end
    checks++; if (a_latch[bl + 1] - a_bfall[bbf] != 1 || a_latch[bl + 2] - a_bfall[bbf + 1] != 1) begin
      errors++; $display("FAIL burst_busy_gap got=%0d,%0d want=1,1", a_latch[bl + 1] - a_bfall[bbf], a_latch[bl + 2] - a_bfall[bbf + 1]);
    end
    checks++; if (a_empty !== 1'b1 || a_busy !== 1'b0 || a_sclk !== 1'b0) begin
      errors++; $display("FAIL burst_idle empty/busy/sclk got=%b%b%b want=100", a_empty, a_busy, a_sclk);
    end
    en_a = 1'b0;
  endtask

  task automatic test_lsb;
    int bd = b_done_q.size(), bb = b_bits.size(), p0 = b_pulses;
    logic [7:0] v = '0;
    push_b(8'hC1);
    en_b = 1'b1;
    for (int i = 0; i < 200 && b_done_q.size() < bd + 1; i++) @(negedge clk);
    checks++; if (b_done_q.size() < bd + 1) begin
      errors++; $display("FAIL lsb_timeout got=%0d want=1 dones", b_done_q.size() - bd);
    end
    en_b = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) v[i] = b_bits[bb + i];
    checks++; if (v !== 8'hC1) begin errors++; $display("FAIL lsb_bits got=%h want=c1", v); end
    checks++; if (b_pulses - p0 != 1 || b_empty !== 1'b1) begin
      errors++; $display("FAIL lsb_pop pulses/empty got=%0d/%b want=1/1", b_pulses - p0, b_empty);
    end
  endtask

  task automatic test_reset_mid;
    int bb = a_bits.size(), bl;
    push_a(8'hFF);
    en_a = 1'b1;
    for (int i = 0; i < 200 && a_bits.size() < bb + 2; i++) @(negedge clk);
    checks++; if (a_bits.size() < bb + 2) begin
      errors++; $display("FAIL rstmid_timeout got=%0d want=2 rises", a_bits.size() - bb);
    end
    checks++; if (a_mosi !== 1'b1 || a_busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre mosi/busy got=%b%b want=11", a_mosi, a_busy);
    end
    reset_n = 1'b0;
    en_a = 1'b0;
    @(negedge clk);
    checks++; if ({a_sclk, a_mosi, a_busy, a_read, a_done} !== 5'b0) begin
      errors++; $display("FAIL rstmid_outputs got=%b want=00000", {a_sclk, a_mosi, a_busy, a_read, a_done});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bb = a_bits.size();
    bl = a_latch.size();
    repeat (20) @(negedge clk);
    checks++; if (a_bits.size() != bb || a_latch.size() != bl) begin
      errors++; $display("FAIL rstmid_quiet rises/latches got=%0d/%0d want=0/0", a_bits.size() - bb, a_latch.size() - bl);
    end
  endtask

  task automatic test_enable_drop;
    int bl = a_latch.size(), bd = a_done_q.size(), bb = a_bits.size(), p0 = a_pulses;
    logic [7:0] v = '0;
    push_a(8'hFF);
    push_a(8'h00);
    en_a = 1'b1;
    for (int i = 0; i < 200 && a_bits.size() < bb + 3; i++) @(negedge clk);
    en_a = 1'b0;
    for (int i = 0; i < 200 && a_done_q.size() < bd + 1; i++) @(negedge clk);
    checks++; if (a_done_q.size() < bd + 1) begin
      errors++; $display("FAIL endrop_timeout got=%0d want=1 dones", a_done_q.size() - bd);
    end
    repeat (60) @(negedge clk);
    for (int i = 0; i < 8; i++) v = {v[6:0], a_bits[bb + i]};
    checks++; if (v !== 8'hFF || a_bits.size() - bb != 8) begin
      errors++; $display("FAIL endrop_bits got=%h/%0d want=ff/8", v, a_bits.size() - bb);
    end
    checks++; if (a_pulses - p0 != 1 || a_latch.size() - bl != 1) begin
      errors++; $display("FAIL endrop_reads got=%0d/%0d want=1/1", a_pulses - p0, a_latch.size() - bl);
    end
    checks++; if (a_empty !== 1'b0 || a_q !== 8'h00) begin
      errors++; $display("FAIL endrop_fifo empty/head got=%b/%h want=0/00", a_empty, a_q);
    end
  endtask

`ifdef FIFO_SPI_TX_CS_EN
  task automatic test_cs;
    int bl = a_latch.size(), bd = a_done_q.size(), cf = cs_fall.size(), cr = cs_rise.size();
    push_a(8'h5A);
    en_a = 1'b1;
    for (int i = 0; i < 400 && a_done_q.size() < bd + 2; i++) @(negedge clk);
    checks++; if (a_done_q.size() < bd + 2) begin
      errors++; $display("FAIL cs_timeout got=%0d want=2 dones", a_done_q.size() - bd);
    end
    repeat (20) @(negedge clk);
    en_a = 1'b0;
    checks++; if (cs_fall.size() - cf != 1 || cs_fall[cf] != a_latch[bl]) begin
      errors++; $display("FAIL cs_fall count/offset got=%0d/%0d want=1/0", cs_fall.size() - cf, cs_fall[cf] - a_latch[bl]);
    end
    checks++; if (cs_rise.size() - cr != 1 || cs_rise[cr] - a_done_q[bd + 1] != 4) begin
      errors++; $display("FAIL cs_rise count/offset got=%0d/%0d want=1/4", cs_rise.size() - cr, cs_rise[cr] - a_done_q[bd + 1]);
    end
    checks++; if (a_cs_n !== 1'b1) begin errors++; $display("FAIL cs_idle got=%b want=1", a_cs_n); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_lsb;
    test_reset_mid;
    test_enable_drop;
`ifdef FIFO_SPI_TX_CS_EN
    test_cs;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
